serializador_tx: RTL
====================

Name: serializador_tx

Overview:
- Transmit-side parallel-to-serial stage. Sits directly upstream of the 8-bit deserializer and drives its data and DK bit inputs.
- Accepts BITS-wide words with per-bit DK flags over a valid/ready handshake.
- Shifts words out MSB first, one bit per clk, matching the deserializer's MSB-first capture.
- Inserts idle comma words when no data is available, and sends a sync preamble after reset.

Parameters:
- BITS, 8, word width; all buses are BITS wide.
- IDLE_WORD, 8'hBC, comma/idle pattern; always sent with all DK bits = 1.
- SYNC_WORDS, 4, number of idle words forced after reset before any data is accepted.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- in_data  input  BITS  parallel data word.
- in_DK  input  BITS  per-bit control (K) flags for in_data.
- in_valid  input  1  in_data/in_DK valid.
- in_ready  output  1  block can accept a word this cycle.
- data_out  output  1  serial data bit, registered.
- DK_out  output  1  serial DK bit, registered.
- frame_start  output  1  high while the MSB of a word is on data_out.
- sync_done  output  1  high once the preamble has completed.

Behaviour:
- Reset is asynchronous, active-low. While reset_L=0:
  - state=SYNC, bit counter cnt=0, sync counter=0, hold_valid=0.
  - Shifter is loaded with IDLE_WORD, DK shifter with all ones.
  - data_out=IDLE_WORD[BITS-1]=1, DK_out=1, frame_start=1, in_ready=0, sync_done=0.
- cnt is $clog2(BITS) bits wide.
  - Increments each posedge and wraps BITS-1 -> 0.
  - frame_start is high exactly when cnt==0.
- data_out/DK_out always equal the shifter MSBs. Between word boundaries the shifters shift left by 1 each posedge.
- Word boundary is the posedge with cnt==BITS-1. At that edge the shifters reload in this priority:
  - hold register contents, if hold_valid;
  - otherwise the handshaked input word (bypass), if the handshake occurs that same edge;
  - otherwise IDLE_WORD with DK all ones.
- Handshake: a word is accepted on a posedge where in_valid && in_ready.
  - in_ready = (state==ACTIVE) && (!hold_valid || cnt==BITS-1). It is combinational from registered state only, never from in_valid.
  - An accepted word not bypassed goes to the hold register (hold_valid=1).
  - hold_valid clears when the hold register is consumed, unless it is refilled at the same edge.
  - At a boundary with hold_valid=1 and a handshake: the hold word goes to the shifter and the new word goes to hold (back-to-back streaming, no idle gap).
- Latency:
  - A word accepted with hold empty at cnt=k (k<BITS-1) has its MSB on data_out after the next boundary edge.
  - A word accepted at a boundary edge via bypass has its MSB on data_out the following cycle.
  - Maximum sustained throughput is 1 word per BITS cycles.
- FSM:
  - SYNC: counts transmitted words at boundaries. After SYNC_WORDS idle words complete -> ACTIVE, and sync_done=1 from that edge on.
  - ACTIVE: normal operation. There is no exit except reset.
- Words with in_valid=0 are never sent. An empty pipeline always transmits IDLE_WORD continuously.
- in_data/in_DK are don't-care when in_valid=0. If in_valid is held while in_ready=0, the word must persist; the block does not drop or duplicate it.
- Reset asserted mid-word abandons the current word and the hold contents immediately (asynchronous). After release the sync preamble restarts from word 0.

Decomposition:
- Shared package holds:
  - BITS default and IDLE_WORD (8'hBC);
  - state encoding localparams (SYNC=0, ACTIVE=1);
  - the counter width function.
- One natural sub-module: serializador_shift, holding the BITS-wide data+DK shifters with load/shift controls and the bit counter.
- The FSM, hold register and handshake stay in the top.

Test Plan:
- Reset release, in_valid=0 -> first 4*8=32 bits are the repeating pattern 1,0,1,1,1,1,0,0 with DK_out=1; frame_start high every 8th cycle; sync_done rises at bit 32; in_ready=0 throughout.
- After sync, single word 8'hA5 with DK=8'h00 offered when cnt=3 -> accepted at the first edge (into hold); next frame emits 1,0,1,0,0,1,0,1 with DK_out=0; then the idle pattern resumes.
- Back-to-back stream 8'h01, 8'h02, 8'h03 with in_valid held high -> three consecutive frames with no idle gap; in_ready pulses once per 8 cycles; no duplication or loss.
- Word with in_DK=8'hFF and in_data=8'h3C -> DK_out=1 for all 8 bits of that frame, data 0,0,1,1,1,1,0,0.
- Reset pulse at cnt=4 mid-word with hold full -> outputs snap to idle/reset values asynchronously; hold is discarded; the full 4-word preamble repeats before in_ready rises.
- Loopback into the deserializer with a random stream of 200 words -> deserializer out/out_DK match the sent words in order, once frame-aligned.

Source files
------------

// File: rtl/serializador_tx_pkg.sv
// Shared definitions for the serializer transmit slice.
package serializador_tx_pkg;

  localparam int         BITS_DEF       = 8;
  localparam logic [7:0] IDLE_WORD_DEF  = 8'hBC;
  localparam int         SYNC_WORDS_DEF = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializador_shift.sv
// Data and DK shift registers plus the bit-position counter.
// Every word boundary reloads both shifters from load_data/load_dk;
// every other edge shifts them left by one, MSB first on the line.
module serializador_shift
  import serializador_tx_pkg::*;
#(
  parameter int             BITS      = BITS_DEF,
  parameter logic [BITS-1:0] IDLE_WORD = BITS'(IDLE_WORD_DEF)
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [BITS-1:0] load_data,
  input  logic [BITS-1:0] load_dk,
  output logic            boundary,
  output logic            frame_start,
  output logic            data_out,
  output logic            dk_out
);

  localparam int              CW       = cnt_width(BITS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BITS - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] data_sh_q, data_sh_d;
  logic [BITS-1:0] dk_sh_q, dk_sh_d;

  assign boundary    = (cnt_q == CNT_LAST);
  assign frame_start = (cnt_q == '0);
  assign data_out    = data_sh_q[BITS-1];
  assign dk_out      = dk_sh_q[BITS-1];

  // Next counter and shifter contents: reload at the boundary, shift otherwise.
  always_comb begin
    cnt_d     = boundary ? '0 : cnt_q + CW'(1);
    data_sh_d = {data_sh_q[BITS-2:0], 1'b0};
    dk_sh_d   = {dk_sh_q[BITS-2:0], 1'b0};
    if (boundary) begin
      data_sh_d = load_data;
      dk_sh_d   = load_dk;
    end
  end

  // Register the counter and shifters; reset parks an idle word on the line.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q     <= '0;
      data_sh_q <= IDLE_WORD;
      dk_sh_q   <= '1;
    end else begin
      cnt_q     <= cnt_d;
      data_sh_q <= data_sh_d;
      dk_sh_q   <= dk_sh_d;
    end
  end

endmodule

// File: rtl/serializador_tx.sv
// Transmit serializer: sync preamble FSM, one-word hold register and
// valid/ready intake feeding the shift stage.
//
// state  | meaning
// SYNC   | sending the idle preamble, intake closed
// ACTIVE | normal streaming, idle words fill gaps
module serializador_tx
  import serializador_tx_pkg::*;
#(
  parameter int              BITS       = BITS_DEF,
  parameter logic [BITS-1:0] IDLE_WORD  = BITS'(IDLE_WORD_DEF),
  parameter int              SYNC_WORDS = SYNC_WORDS_DEF
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [BITS-1:0] in_data,
  input  logic [BITS-1:0] in_DK,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            data_out,
  output logic            DK_out,
  output logic            frame_start,
  output logic            sync_done
);

  localparam int            SW        = cnt_width(SYNC_WORDS);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_WORDS - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   sync_cnt_q, sync_cnt_d;
  logic [BITS-1:0] hold_data_q, hold_data_d;
  logic [BITS-1:0] hold_dk_q, hold_dk_d;
  logic            hold_valid_q, hold_valid_d;
  logic [BITS-1:0] load_data, load_dk;
  logic            boundary;
  logic            accept;

  // Ready depends only on registered state so it never loops through in_valid.
  assign in_ready  = (state_q == ACTIVE) && (!hold_valid_q || boundary);
  assign accept    = in_valid && in_ready;
  assign sync_done = (state_q == ACTIVE);

  // Boundary reload priority (hold, bypass, idle), hold refill and preamble count.
  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    hold_data_d  = hold_data_q;
    hold_dk_d    = hold_dk_q;
    hold_valid_d = hold_valid_q;
    load_data    = IDLE_WORD;
    load_dk      = '1;
    if (boundary) begin
      if (hold_valid_q) begin
        load_data    = hold_data_q;
        load_dk      = hold_dk_q;
        hold_valid_d = accept;
        if (accept) begin
          hold_data_d = in_data;
          hold_dk_d   = in_DK;
        end
      end else if (accept) begin
        load_data = in_data;
        load_dk   = in_DK;
      end
      if (state_q == SYNC) begin
        if (sync_cnt_q == SYNC_LAST) state_d = ACTIVE;
        else                         sync_cnt_d = sync_cnt_q + SW'(1);
      end
    end else if (accept) begin
      hold_data_d  = in_data;
      hold_dk_d    = in_DK;
      hold_valid_d = 1'b1;
    end
  end

  // State, preamble counter and hold register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= SYNC;
      sync_cnt_q   <= '0;
      hold_data_q  <= '0;
      hold_dk_q    <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_dk_q    <= hold_dk_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  serializador_shift #(
    .BITS      (BITS),
    .IDLE_WORD (IDLE_WORD)
  ) u_shift (
    .clk         (clk),
    .reset_L     (reset_L),
    .load_data   (load_data),
    .load_dk     (load_dk),
    .boundary    (boundary),
    .frame_start (frame_start),
    .data_out    (data_out),
    .dk_out      (DK_out)
  );

endmodule
